multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
Parametrised multi-cycle control unit for the MIPS32 datapath. It drives every datapath strobe from an explicit state machine, not from a fixed time-step table. Compared with the fixed-step generation, it adds:
- configurable fetch latency;
- a ready-handshake with data memory for variable-latency loads and stores;
- a halt/resume handshake;
- an instruction-done pulse.

It sits between instruction_decoder (which supplies the class index) and the datapath register/mux controls.

Parameters:
FETCH_CYCLES, 3, cycles spent in FETCH; range 1..8
CLASS_W, 4, width of instruction class index
MEM_TIMEOUT, 64, max cycles waiting for mem_ready (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock
reset_all  in  1  synchronous active-high reset
op_class  in  CLASS_W  class index from instruction_decoder; stable from EXEC onward
mem_ready  in  1  data memory completes access this cycle
halt_resume  in  1  HALT button; resumes from HALT
load_pc, reset_pc, en_imem, load_ir  out  1 each  PC/IR controls
rf_en, rf_rd, rf_wr, src1, src2, sel_comp, sel_pc, is_branch  out  1 each  regfile/ALU controls
sel_signal  out  2  immediate-extension select
dmem_en, dmem_we, load_lmd, write_data, write_port  out  1 each  memory/writeback controls
halted  out  1  high in HALT
instr_done  out  1  one-cycle pulse in the last cycle of every instruction
illegal  out  1  one-cycle pulse when op_class is illegal
mem_err  out  1  sticky memory timeout flag
step  out  4  cycle count within current instruction, saturates at 15

Behaviour:
Interface rules (already decided):
- One clock, clk.
- Synchronous active-high reset, reset_all.

Reset:
- While reset_all=1: reset_pc=1, all other outputs 0, step=0, mem_err=0.
- Next state is FETCH with step 0.
- reset_all mid-instruction aborts it; any pending memory access is dropped (dmem_en=0 next cycle).

Output decoding:
- Outputs are decoded from state and op_class.
- Any output not listed for a state is 0.

States:
- FETCH:
  - en_imem=1, load_ir=1 for FETCH_CYCLES cycles.
  - Then go to EXEC.
- EXEC (1 cycle), actions by class:
  - Classes 1..4 (ALU): rf_en=1, rf_wr=1, src1=1, src2=1, is_branch=1, load_pc=1.
    - rf_rd=0 for class 1, else rf_rd=1.
    - sel_pc=1 for class 1.
    - sel_signal = 00, 01, 11, 10 for classes 1..4 respectively.
    - Next: FETCH.
  - Class 5 (load): go to MEM_RD.
  - Class 6 (store): go to MEM_WR.
  - Classes 7, 8 (compare): rf_en, rf_rd, rf_wr, sel_comp, load_pc = 1. Next: FETCH.
  - Class 9 (cmov): as class 7, plus src2=1 and write_port=1.
  - Class 10 (halt): go to HALT.
  - Class 11 (nop): load_pc=0. Next: FETCH.
  - Class 12 (jump): rf_en, rf_rd, sel_pc, load_pc = 1. Next: FETCH.
  - Illegal classes (0, 13..15): treated as nop, and illegal pulses.
- MEM_RD:
  - rf_en, rf_rd, src2, dmem_en, load_lmd, is_branch = 1; sel_signal=10.
  - Stays until mem_ready=1 is sampled, then goes to WB.
- WB (1 cycle): rf_en, rf_wr, src2, write_data, write_port, load_pc = 1. Next: FETCH.
- MEM_WR:
  - rf_en, rf_rd, src2, dmem_en, dmem_we = 1.
  - load_pc=1 only in the cycle mem_ready=1; then go to FETCH.
- HALT:
  - halted=1, load_pc=0.
  - halt_resume=1 sampled in HALT: load_pc=1 and instr_done=1 that cycle, then FETCH.
  - halt_resume asserted during EXEC of class 10 is ignored.

Step, instr_done, mem_ready rules:
- step increments every cycle and returns to 0 on entering FETCH.
- instr_done fires in the final cycle of each instruction: EXEC for single-cycle classes, WB, the ready cycle of MEM_WR, the resume cycle of HALT.
- mem_ready outside MEM_RD/MEM_WR is ignored.
- reset_all has priority over every transition.

Optional Feature:
MEM_TIMEOUT_EN:
- Defined: a wait counter runs in MEM_RD/MEM_WR.
  - On reaching MEM_TIMEOUT cycles without mem_ready: set mem_err (sticky until reset_all) and go to HALT.
  - Writeback and PC update are suppressed.
  - Resume is still via halt_resume.
- Undefined: waits indefinitely; mem_err is tied to 0 and no counter is synthesised.

Decomposition:
- Package ctrl_pkg holds:
  - state enumeration (FETCH, EXEC, MEM_RD, MEM_WR, WB, HALT);
  - class code constants (CLS_ALU_R..CLS_JUMP);
  - sel_signal encodings;
  - control-bundle struct typedef.
- One sub-module, ctrl_step_counter: the saturating step counter plus the optional timeout counter, with clear and enable inputs.

Test Plan:
- Reset then class 1, FETCH_CYCLES=3:
  - steps 0-2 have load_ir=1;
  - step 3 has load_pc=1, sel_pc=1, rf_wr=1, instr_done=1;
  - step returns to 0.
- Class 5 with mem_ready low for 4 cycles:
  - dmem_en=1 and load_lmd=1 for 5 MEM_RD cycles;
  - WB has rf_wr=1, write_port=1, load_pc=1;
  - total 3+1+5+1 = 10 cycles.
- Class 10: halted=1 for 20 cycles; halt_resume pulse gives load_pc=1 and instr_done=1, then FETCH. Also drive halt_resume during EXEC → no effect.
- reset_all asserted during MEM_WR step 5: next cycle dmem_en=0 and reset_pc=1; after release, FETCH step 0.
- op_class=14 → illegal pulse once, load_pc=0, back to FETCH.
- With MEM_TIMEOUT_EN and MEM_TIMEOUT=8, class 6 with mem_ready held 0: after 8 wait cycles mem_err=1, halted=1, load_pc never asserted.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared types and constants for the multi-cycle MIPS32
//                control unit: state encoding, instruction class codes,
//                immediate-extension selects and the control strobe bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    // Controller states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        EXEC   = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } ctrl_state_t;

    // Instruction class indices delivered by instruction_decoder
    localparam int CLS_ALU_R  = 1;
    localparam int CLS_ALU_I  = 2;
    localparam int CLS_ALU_U  = 3;
    localparam int CLS_ALU_S  = 4;
    localparam int CLS_LOAD   = 5;
    localparam int CLS_STORE  = 6;
    localparam int CLS_CMP_A  = 7;
    localparam int CLS_CMP_B  = 8;
    localparam int CLS_CMOV   = 9;
    localparam int CLS_HALT   = 10;
    localparam int CLS_NOP    = 11;
    localparam int CLS_JUMP   = 12;

    // Immediate-extension select encodings
    localparam logic [1:0] SEL_R_TYPE   = 2'b00;
    localparam logic [1:0] SEL_ZERO_EXT = 2'b01;
    localparam logic [1:0] SEL_UPPER    = 2'b11;
    localparam logic [1:0] SEL_SIGN_EXT = 2'b10;

    // Every datapath strobe driven by the controller
    typedef struct packed {
        logic       load_pc;
        logic       reset_pc;
        logic       en_imem;
        logic       load_ir;
        logic       rf_en;
        logic       rf_rd;
        logic       rf_wr;
        logic       src1;
        logic       src2;
        logic       sel_comp;
        logic       sel_pc;
        logic       is_branch;
        logic [1:0] sel_signal;
        logic       dmem_en;
        logic       dmem_we;
        logic       load_lmd;
        logic       write_data;
        logic       write_port;
        logic       halted;
        logic       instr_done;
        logic       illegal;
    } ctrl_bundle_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_step_counter.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_step_counter
//  Description : Saturating per-instruction step counter, plus an optional
//                memory wait counter that flags a timeout after MEM_TIMEOUT
//                cycles without a ready. The wait counter only exists when
//                the MEM_TIMEOUT_EN macro is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_step_counter #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_wait_en,
    output logic [3:0] o_step,
    output logic       o_timeout
);

    localparam logic [3:0] c_STEP_MAX = 4'd15;

    logic [3:0] r_step;

    // Step counter: cleared on instruction boundary, saturates at 15
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_step <= 4'd0;
        end else if (i_enable && (r_step != c_STEP_MAX)) begin
            r_step <= r_step + 4'd1;
        end
    end

    assign o_step = r_step;

`ifdef MEM_TIMEOUT_EN
    localparam int c_WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    logic [c_WAIT_W-1:0] r_wait;

    // Wait counter: counts cycles spent in a memory state, idles at zero elsewhere
    always_ff @(posedge clk) begin
        if (rst || !i_wait_en) begin
            r_wait <= '0;
        end else if (r_wait != c_WAIT_LAST) begin
            r_wait <= r_wait + c_WAIT_W'(1);
        end
    end

    // The cycle holding the last allowed count is the final wait cycle
    assign o_timeout = i_wait_en && (r_wait == c_WAIT_LAST);
`else
    localparam int c_unused_timeout = MEM_TIMEOUT;
    logic w_unused_wait;

    assign w_unused_wait = i_wait_en;
    assign o_timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_fsm
//  Description : Multi-cycle control unit for the MIPS32 datapath. Drives
//                every datapath strobe from an explicit FSM with
//                configurable fetch latency, data-memory ready handshake,
//                halt/resume handshake and an instruction-done pulse.
//                Optional macro MEM_TIMEOUT_EN adds a memory wait timeout
//                that sets a sticky mem_err and parks the FSM in HALT.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int FETCH_CYCLES = 3,
    parameter int CLASS_W      = 4,
    parameter int MEM_TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               reset_all,
    input  logic [CLASS_W-1:0] op_class,
    input  logic               mem_ready,
    input  logic               halt_resume,
    output logic               load_pc,
    output logic               reset_pc,
    output logic               en_imem,
    output logic               load_ir,
    output logic               rf_en,
    output logic               rf_rd,
    output logic               rf_wr,
    output logic               src1,
    output logic               src2,
    output logic               sel_comp,
    output logic               sel_pc,
    output logic               is_branch,
    output logic [1:0]         sel_signal,
    output logic               dmem_en,
    output logic               dmem_we,
    output logic               load_lmd,
    output logic               write_data,
    output logic               write_port,
    output logic               halted,
    output logic               instr_done,
    output logic               illegal,
    output logic               mem_err,
    output logic [3:0]         step
);

    localparam logic [3:0] c_FETCH_LAST = 4'(FETCH_CYCLES - 1);

    ctrl_state_t  r_state;
    ctrl_state_t  w_next_state;
    ctrl_bundle_t w_ctrl;
    ctrl_bundle_t w_out;
    logic [3:0]   w_step;
    logic         w_timeout;
    logic         w_in_mem;
    logic         w_clear_step;
    logic         w_set_mem_err;

    // State register; reset restarts the instruction in FETCH
    always_ff @(posedge clk) begin
        if (reset_all) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    assign w_in_mem     = (r_state == MEM_RD) || (r_state == MEM_WR);
    assign w_clear_step = (w_next_state == FETCH) && (r_state != FETCH);

    ctrl_step_counter #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_step_counter (
        .clk       (clk),
        .rst       (reset_all),
        .i_clear   (w_clear_step),
        .i_enable  (1'b1),
        .i_wait_en (w_in_mem),
        .o_step    (w_step),
        .o_timeout (w_timeout)
    );

    // Next-state and strobe decode from current state and instruction class
    always_comb begin
        w_next_state  = r_state;
        w_ctrl        = '0;
        w_set_mem_err = 1'b0;
        case (r_state)
            FETCH: begin
                w_ctrl.en_imem = 1'b1;
                w_ctrl.load_ir = 1'b1;
                if (w_step == c_FETCH_LAST) begin
                    w_next_state = EXEC;
                end
            end
            EXEC: begin
                w_next_state      = FETCH;
                w_ctrl.instr_done = 1'b1;
                case (int'(op_class))
                    CLS_ALU_R, CLS_ALU_I, CLS_ALU_U, CLS_ALU_S: begin
                        w_ctrl.rf_en     = 1'b1;
                        w_ctrl.rf_wr     = 1'b1;
                        w_ctrl.src1      = 1'b1;
                        w_ctrl.src2      = 1'b1;
                        w_ctrl.is_branch = 1'b1;
                        w_ctrl.load_pc   = 1'b1;
                        w_ctrl.rf_rd     = (int'(op_class) != CLS_ALU_R);
                        w_ctrl.sel_pc    = (int'(op_class) == CLS_ALU_R);
                        case (int'(op_class))
                            CLS_ALU_I: w_ctrl.sel_signal = SEL_ZERO_EXT;
                            CLS_ALU_U: w_ctrl.sel_signal = SEL_UPPER;
                            CLS_ALU_S: w_ctrl.sel_signal = SEL_SIGN_EXT;
                            default:   w_ctrl.sel_signal = SEL_R_TYPE;
                        endcase
                    end
                    CLS_LOAD: begin
                        w_next_state      = MEM_RD;
                        w_ctrl.instr_done = 1'b0;
                    end
                    CLS_STORE: begin
                        w_next_state      = MEM_WR;
                        w_ctrl.instr_done = 1'b0;
                    end
                    CLS_CMP_A, CLS_CMP_B, CLS_CMOV: begin
                        w_ctrl.rf_en      = 1'b1;
                        w_ctrl.rf_rd      = 1'b1;
                        w_ctrl.rf_wr      = 1'b1;
                        w_ctrl.sel_comp   = 1'b1;
                        w_ctrl.load_pc    = 1'b1;
                        w_ctrl.src2       = (int'(op_class) == CLS_CMOV);
                        w_ctrl.write_port = (int'(op_class) == CLS_CMOV);
                    end
                    CLS_HALT: begin
                        // halt_resume is deliberately not looked at here
                        w_next_state      = HALT;
                        w_ctrl.instr_done = 1'b0;
                    end
                    CLS_NOP: begin
                        w_ctrl.load_pc = 1'b0;
                    end
                    CLS_JUMP: begin
                        w_ctrl.rf_en   = 1'b1;
                        w_ctrl.rf_rd   = 1'b1;
                        w_ctrl.sel_pc  = 1'b1;
                        w_ctrl.load_pc = 1'b1;
                    end
                    default: begin
                        // Unknown class behaves as a nop and flags itself
                        w_ctrl.illegal = 1'b1;
                    end
                endcase
            end
            MEM_RD: begin
                w_ctrl.rf_en      = 1'b1;
                w_ctrl.rf_rd      = 1'b1;
                w_ctrl.src2       = 1'b1;
                w_ctrl.dmem_en    = 1'b1;
                w_ctrl.load_lmd   = 1'b1;
                w_ctrl.is_branch  = 1'b1;
                w_ctrl.sel_signal = SEL_SIGN_EXT;
                if (mem_ready) begin
                    w_next_state = WB;
                end else if (w_timeout) begin
                    w_next_state  = HALT;
                    w_set_mem_err = 1'b1;
                end
            end
            WB: begin
                w_ctrl.rf_en      = 1'b1;
                w_ctrl.rf_wr      = 1'b1;
                w_ctrl.src2       = 1'b1;
                w_ctrl.write_data = 1'b1;
                w_ctrl.write_port = 1'b1;
                w_ctrl.load_pc    = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_next_state      = FETCH;
            end
            MEM_WR: begin
                w_ctrl.rf_en   = 1'b1;
                w_ctrl.rf_rd   = 1'b1;
                w_ctrl.src2    = 1'b1;
                w_ctrl.dmem_en = 1'b1;
                w_ctrl.dmem_we = 1'b1;
                if (mem_ready) begin
                    w_ctrl.load_pc    = 1'b1;
                    w_ctrl.instr_done = 1'b1;
                    w_next_state      = FETCH;
                end else if (w_timeout) begin
                    w_next_state  = HALT;
                    w_set_mem_err = 1'b1;
                end
            end
            HALT: begin
                w_ctrl.halted = 1'b1;
                if (halt_resume) begin
                    w_ctrl.load_pc    = 1'b1;
                    w_ctrl.instr_done = 1'b1;
                    w_next_state      = FETCH;
                end
            end
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

    // While reset is held only reset_pc is driven, regardless of state
    always_comb begin
        w_out = w_ctrl;
        if (reset_all) begin
            w_out          = '0;
            w_out.reset_pc = 1'b1;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic r_mem_err;

    // Sticky timeout flag, cleared only by reset_all
    always_ff @(posedge clk) begin
        if (reset_all) begin
            r_mem_err <= 1'b0;
        end else if (w_set_mem_err) begin
            r_mem_err <= 1'b1;
        end
    end

    assign mem_err = r_mem_err && !reset_all;
`else
    logic w_unused_mem_err;

    assign w_unused_mem_err = w_set_mem_err;
    assign mem_err          = 1'b0;
`endif

    assign load_pc    = w_out.load_pc;
    assign reset_pc   = w_out.reset_pc;
    assign en_imem    = w_out.en_imem;
    assign load_ir    = w_out.load_ir;
    assign rf_en      = w_out.rf_en;
    assign rf_rd      = w_out.rf_rd;
    assign rf_wr      = w_out.rf_wr;
    assign src1       = w_out.src1;
    assign src2       = w_out.src2;
    assign sel_comp   = w_out.sel_comp;
    assign sel_pc     = w_out.sel_pc;
    assign is_branch  = w_out.is_branch;
    assign sel_signal = w_out.sel_signal;
    assign dmem_en    = w_out.dmem_en;
    assign dmem_we    = w_out.dmem_we;
    assign load_lmd   = w_out.load_lmd;
    assign write_data = w_out.write_data;
    assign write_port = w_out.write_port;
    assign halted     = w_out.halted;
    assign instr_done = w_out.instr_done;
    assign illegal    = w_out.illegal;
    assign step       = reset_all ? 4'd0 : w_step;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl_fsm
//  Description : Directed self-checking bench for multicycle_ctrl_fsm
//                (FETCH_CYCLES=3, MEM_TIMEOUT=8). The timeout scenario is
//                built when MEM_TIMEOUT_EN is defined, the indefinite-wait
//                scenario otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl_fsm;

    localparam int FETCH_CYCLES = 3;
    localparam int CLASS_W      = 4;
    localparam int MEM_TIMEOUT  = 8;

    logic         clk = 1'b0;
    logic         reset_all;
    logic [3:0]   op_class;
    logic         mem_ready;
    logic         halt_resume;
    logic         load_pc, reset_pc, en_imem, load_ir;
    logic         rf_en, rf_rd, rf_wr, src1, src2, sel_comp, sel_pc, is_branch;
    logic [1:0]   sel_signal;
    logic         dmem_en, dmem_we, load_lmd, write_data, write_port;
    logic         halted, instr_done, illegal, mem_err;
    logic [3:0]   step;
    logic [21:0]  others;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign others = {load_pc, en_imem, load_ir, rf_en, rf_rd, rf_wr, src1, src2,
                     sel_comp, sel_pc, is_branch, sel_signal, dmem_en, dmem_we,
                     load_lmd, write_data, write_port, halted, instr_done,
                     illegal, mem_err};

    multicycle_ctrl_fsm #(
        .FETCH_CYCLES (FETCH_CYCLES),
        .CLASS_W      (CLASS_W),
        .MEM_TIMEOUT  (MEM_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_all   (reset_all),
        .op_class    (op_class),
        .mem_ready   (mem_ready),
        .halt_resume (halt_resume),
        .load_pc     (load_pc),
        .reset_pc    (reset_pc),
        .en_imem     (en_imem),
        .load_ir     (load_ir),
        .rf_en       (rf_en),
        .rf_rd       (rf_rd),
        .rf_wr       (rf_wr),
        .src1        (src1),
        .src2        (src2),
        .sel_comp    (sel_comp),
        .sel_pc      (sel_pc),
        .is_branch   (is_branch),
        .sel_signal  (sel_signal),
        .dmem_en     (dmem_en),
        .dmem_we     (dmem_we),
        .load_lmd    (load_lmd),
        .write_data  (write_data),
        .write_port  (write_port),
        .halted      (halted),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .mem_err     (mem_err),
        .step        (step)
    );

    // Move to 1 time unit after the next rising edge
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic skip_fetch();
        repeat (FETCH_CYCLES) adv();
    endtask

    task automatic test_reset();
        reset_all = 1'b1; op_class = 4'd0; mem_ready = 1'b0; halt_resume = 1'b0;
        adv(); adv(); #1;
        n_tests++; if (reset_pc !== 1'b1) begin n_fail++; $display("FAIL reset_pc: got %b want 1", reset_pc); end
        n_tests++; if (others !== 22'd0) begin n_fail++; $display("FAIL reset_others: got %h want 0", others); end
        n_tests++; if (step !== 4'd0) begin n_fail++; $display("FAIL reset_step: got %0d want 0", step); end
        n_tests++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err: got %b want 0", mem_err); end
        reset_all = 1'b0;
    endtask

    task automatic test_alu();
        op_class = 4'd1;
        for (int s = 0; s < FETCH_CYCLES; s++) begin
            #1;
            n_tests++;
            if ({en_imem, load_ir, load_pc, step} !== {3'b110, 4'(s)}) begin
                n_fail++; $display("FAIL alu_fetch s%0d: got %b want %b", s, {en_imem, load_ir, load_pc, step}, {3'b110, 4'(s)});
            end
            adv();
        end
        #1;
        n_tests++;
        if ({load_pc, sel_pc, rf_wr, rf_rd, instr_done, sel_signal, step} !== {5'b11101, 2'b00, 4'd3}) begin
            n_fail++; $display("FAIL alu_exec: got %b want %b", {load_pc, sel_pc, rf_wr, rf_rd, instr_done, sel_signal, step}, {5'b11101, 2'b00, 4'd3});
        end
        adv(); #1;
        n_tests++;
        if ({step, load_ir, instr_done} !== {4'd0, 2'b10}) begin
            n_fail++; $display("FAIL alu_refetch: got %b want %b", {step, load_ir, instr_done}, {4'd0, 2'b10});
        end
    endtask

    task automatic test_alu_classes();
        logic [1:0] exp_sel [3] = '{2'b01, 2'b11, 2'b10};
        for (int c = 0; c < 3; c++) begin
            op_class = 4'(c + 2);
            skip_fetch(); #1;
            n_tests++;
            if ({rf_rd, sel_pc, rf_wr, load_pc, instr_done, sel_signal} !== {5'b10111, exp_sel[c]}) begin
                n_fail++; $display("FAIL alu_class%0d: got %b want %b", c + 2, {rf_rd, sel_pc, rf_wr, load_pc, instr_done, sel_signal}, {5'b10111, exp_sel[c]});
            end
            adv();
        end
    endtask

    task automatic test_single_cycle();
        // {illegal, load_pc, sel_pc, sel_comp, rf_wr, rf_rd, src2, write_port, instr_done}
        logic [3:0] cls [7] = '{4'd14, 4'd0, 4'd11, 4'd12, 4'd7, 4'd8, 4'd9};
        logic [8:0] exp [7] = '{9'b100000001, 9'b100000001, 9'b000000001, 9'b011001001,
                                9'b010111001, 9'b010111001, 9'b010111111};
        for (int i = 0; i < 7; i++) begin
            op_class = cls[i];
            skip_fetch(); #1;
            n_tests++;
            if ({illegal, load_pc, sel_pc, sel_comp, rf_wr, rf_rd, src2, write_port, instr_done} !== exp[i]) begin
                n_fail++; $display("FAIL class%0d_exec: got %b want %b", cls[i], {illegal, load_pc, sel_pc, sel_comp, rf_wr, rf_rd, src2, write_port, instr_done}, exp[i]);
            end
            adv(); #1;
            n_tests++;
            if ({illegal, step, load_ir} !== {1'b0, 4'd0, 1'b1}) begin
                n_fail++; $display("FAIL class%0d_after: got %b want %b", cls[i], {illegal, step, load_ir}, {1'b0, 4'd0, 1'b1});
            end
        end
    endtask

    task automatic test_load();
        op_class = 4'd5;
        skip_fetch(); #1;
        n_tests++;
        if ({dmem_en, load_pc, instr_done, step} !== {3'b000, 4'd3}) begin
            n_fail++; $display("FAIL load_exec: got %b want %b", {dmem_en, load_pc, instr_done, step}, {3'b000, 4'd3});
        end
        adv();
        for (int i = 0; i < 5; i++) begin
            mem_ready = (i == 4);
            #1;
            n_tests++;
            if ({dmem_en, load_lmd, is_branch, sel_signal, instr_done, rf_wr, step} !== {3'b111, 2'b10, 2'b00, 4'(4 + i)}) begin
                n_fail++; $display("FAIL load_memrd%0d: got %b want %b", i, {dmem_en, load_lmd, is_branch, sel_signal, instr_done, rf_wr, step}, {3'b111, 2'b10, 2'b00, 4'(4 + i)});
            end
            adv();
        end
        mem_ready = 1'b0; #1;
        n_tests++;
        if ({rf_wr, write_port, write_data, load_pc, instr_done, dmem_en, step} !== {6'b111110, 4'd9}) begin
            n_fail++; $display("FAIL load_wb: got %b want %b", {rf_wr, write_port, write_data, load_pc, instr_done, dmem_en, step}, {6'b111110, 4'd9});
        end
        adv(); #1;
        n_tests++; if ({step, load_ir} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL load_refetch: got %b want %b", {step, load_ir}, {4'd0, 1'b1}); end
    endtask

    task automatic test_store();
        op_class = 4'd6; mem_ready = 1'b1;  // ready outside memory states must be ignored
        skip_fetch(); #1;
        n_tests++;
        if ({dmem_en, load_pc, instr_done} !== 3'b000) begin
            n_fail++; $display("FAIL store_exec: got %b want 000", {dmem_en, load_pc, instr_done});
        end
        adv();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            #1;
            n_tests++;
            if ({dmem_en, dmem_we, rf_rd, src2, load_pc, instr_done, step} !== {4'b1111, {2{(i == 2)}}, 4'(4 + i)}) begin
                n_fail++; $display("FAIL store_memwr%0d: got %b want %b", i, {dmem_en, dmem_we, rf_rd, src2, load_pc, instr_done, step}, {4'b1111, {2{(i == 2)}}, 4'(4 + i)});
            end
            adv();
        end
        mem_ready = 1'b0; #1;
        n_tests++; if ({step, load_ir, dmem_en} !== {4'd0, 2'b10}) begin n_fail++; $display("FAIL store_refetch: got %b want %b", {step, load_ir, dmem_en}, {4'd0, 2'b10}); end
    endtask

    task automatic test_halt();
        op_class = 4'd10; halt_resume = 1'b1;  // pressed through FETCH and EXEC
        skip_fetch(); #1;
        n_tests++;
        if ({halted, load_pc, instr_done} !== 3'b000) begin
            n_fail++; $display("FAIL halt_exec: got %b want 000", {halted, load_pc, instr_done});
        end
        adv();
        halt_resume = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_tests++;
            if ({halted, load_pc, instr_done, en_imem} !== 4'b1000) begin
                n_fail++; $display("FAIL halt_wait%0d: got %b want 1000", i, {halted, load_pc, instr_done, en_imem});
            end
            adv();
        end
        halt_resume = 1'b1; #1;
        n_tests++;
        if ({halted, load_pc, instr_done, step} !== {3'b111, 4'd15}) begin
            n_fail++; $display("FAIL halt_resume: got %b want %b", {halted, load_pc, instr_done, step}, {3'b111, 4'd15});
        end
        adv();
        halt_resume = 1'b0; #1;
        n_tests++; if ({halted, step, load_ir} !== {1'b0, 4'd0, 1'b1}) begin n_fail++; $display("FAIL halt_refetch: got %b want %b", {halted, step, load_ir}, {1'b0, 4'd0, 1'b1}); end
    endtask

    task automatic test_reset_mid();
        op_class = 4'd6;
        skip_fetch(); adv(); adv(); #1;
        n_tests++;
        if ({dmem_en, dmem_we, step} !== {2'b11, 4'd5}) begin
            n_fail++; $display("FAIL abort_pre: got %b want %b", {dmem_en, dmem_we, step}, {2'b11, 4'd5});
        end
        reset_all = 1'b1;
        adv(); #1;
        n_tests++;
        if ({dmem_en, reset_pc, step} !== {2'b01, 4'd0}) begin
            n_fail++; $display("FAIL abort_reset: got %b want %b", {dmem_en, reset_pc, step}, {2'b01, 4'd0});
        end
        adv();
        reset_all = 1'b0; #1;
        n_tests++;
        if ({reset_pc, en_imem, load_ir, dmem_en, step} !== {4'b0110, 4'd0}) begin
            n_fail++; $display("FAIL abort_fetch: got %b want %b", {reset_pc, en_imem, load_ir, dmem_en, step}, {4'b0110, 4'd0});
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        op_class = 4'd6; mem_ready = 1'b0;
        skip_fetch(); adv();
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            #1;
            n_tests++;
            if ({dmem_en, load_pc, mem_err, halted} !== 4'b1000) begin
                n_fail++; $display("FAIL tmo_wait%0d: got %b want 1000", i, {dmem_en, load_pc, mem_err, halted});
            end
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if ({halted, mem_err, load_pc, dmem_en, instr_done} !== 5'b11000) begin
                n_fail++; $display("FAIL tmo_halt%0d: got %b want 11000", i, {halted, mem_err, load_pc, dmem_en, instr_done});
            end
            adv();
        end
        halt_resume = 1'b1; #1;
        n_tests++;
        if ({load_pc, instr_done, mem_err} !== 3'b111) begin
            n_fail++; $display("FAIL tmo_resume: got %b want 111", {load_pc, instr_done, mem_err});
        end
        adv();
        halt_resume = 1'b0; #1;
        n_tests++; if ({mem_err, step, load_ir} !== {1'b1, 4'd0, 1'b1}) begin n_fail++; $display("FAIL tmo_sticky: got %b want %b", {mem_err, step, load_ir}, {1'b1, 4'd0, 1'b1}); end
        reset_all = 1'b1; adv(); #1;
        n_tests++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", mem_err); end
        reset_all = 1'b0;
    endtask
`else
    task automatic test_no_timeout();
        op_class = 4'd6; mem_ready = 1'b0;
        skip_fetch(); adv();
        for (int i = 0; i < 12; i++) begin
            #1;
            n_tests++;
            if ({dmem_en, halted, mem_err, load_pc} !== 4'b1000) begin
                n_fail++; $display("FAIL wait%0d: got %b want 1000", i, {dmem_en, halted, mem_err, load_pc});
            end
            adv();
        end
        mem_ready = 1'b1; #1;
        n_tests++; if ({load_pc, instr_done, step} !== {2'b11, 4'd15}) begin n_fail++; $display("FAIL wait_done: got %b want %b", {load_pc, instr_done, step}, {2'b11, 4'd15}); end
        adv();
        mem_ready = 1'b0; #1;
        n_tests++; if ({step, load_ir} !== {4'd0, 1'b1}) begin n_fail++; $display("FAIL wait_refetch: got %b want %b", {step, load_ir}, {4'd0, 1'b1}); end
    endtask
`endif

    initial begin
        test_reset();
        test_alu();
        test_alu_classes();
        test_single_cycle();
        test_load();
        test_store();
        test_halt();
        test_reset_mid();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time bound, tests=%0d", n_tests);
        $fatal(1, "time bound expired");
    end

endmodule
`default_nettype wire
